// File: rtl/phy_link_ctrl_pkg.sv
// Shared definitions for the PHY link sequencer: sync/idle words, default
// sequencing limits and the link state encoding.
package phy_link_ctrl_pkg;

    localparam int SYNC_WORDS_DEF = 4;
    localparam int LOCK_COUNT_DEF = 3;
    localparam int TIMEOUT_DEF    = 64;

    localparam logic [31:0] COM = 32'hBCBC_BCBC;
    localparam logic [31:0] IDL = 32'h7C7C_7C7C;

    typedef enum logic [1:0] {
        SEND_SYNC = 2'd0,
        WAIT_LOCK = 2'd1,
        ACTIVE    = 2'd2
    } link_state_t;

endpackage

// File: rtl/phy_rr_arb2.sv
// Two-way round-robin arbiter; holds the last-served pointer, which starts at
// requester 1 so requester 0 wins the first contested cycle.
module phy_rr_arb2 (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/phy_link_ctrl.sv
// PHY link sequencer and two-requester transmit arbiter.
// Optional LINK_STATS_EN adds per-requester word counters and a resync counter.
//
// state     | meaning
// SEND_SYNC | request bus sync, transmit COM for SYNC_WORDS cycles
// WAIT_LOCK | keep sending COM, count consecutive received COM words
// ACTIVE    | link up, round-robin requester words onto the PHY
module phy_link_ctrl
    import phy_link_ctrl_pkg::*;
#(
    parameter int SYNC_WORDS = SYNC_WORDS_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        retrain,
    input  logic [31:0] phy_data_out,
    input  logic        phy_valid_out,
    output logic [31:0] phy_data_in,
    output logic        phy_valid_in,
    output logic        sincronizar_bus,
    output logic        link_up
`ifdef LINK_STATS_EN
    ,
    output logic [15:0] tx_cnt0,
    output logic [15:0] tx_cnt1,
    output logic [7:0]  resync_cnt
`endif
);

    localparam int SYNC_W = $clog2(SYNC_WORDS + 1);
    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);
    localparam logic [LOCK_W-1:0] LOCK_DONE = LOCK_W'(LOCK_COUNT);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    link_state_t       state, state_nxt;
    logic [SYNC_W-1:0] sync_cnt, sync_cnt_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic              timeout_hit;

    logic [1:0]  grant;
    logic        arb_en;
    logic        xfer;
    logic [31:0] xfer_data;

    logic [31:0] data_nxt;
    logic        valid_nxt;
    logic        sync_nxt;
    logic        link_nxt;

    // Receive valid carries no information for lock detection.
    logic unused_phy_valid;
    assign unused_phy_valid = phy_valid_out;

    assign arb_en     = (state == ACTIVE) && !retrain;
    assign xfer       = |grant;
    assign xfer_data  = grant[1] ? req1_data : req0_data;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    phy_rr_arb2 u_arb (
        .clk_f  (clk_f),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .enable (arb_en),
        .accept (xfer),
        .grant  (grant)
    );

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state    <= SEND_SYNC;
            sync_cnt <= '0;
            lock_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
            lock_cnt <= lock_cnt_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        lock_cnt_nxt = lock_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        timeout_hit  = 1'b0;
        if (retrain) begin
            state_nxt    = SEND_SYNC;
            sync_cnt_nxt = '0;
            lock_cnt_nxt = '0;
            tmo_cnt_nxt  = '0;
        end else begin
            case (state)
                SEND_SYNC: begin
                    if (sync_cnt == SYNC_LAST) begin
                        state_nxt    = WAIT_LOCK;
                        sync_cnt_nxt = '0;
                    end else begin
                        sync_cnt_nxt = sync_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock wins over a timeout landing on the same cycle.
                    if (lock_cnt == LOCK_DONE) begin
                        state_nxt    = ACTIVE;
                        lock_cnt_nxt = '0;
                        tmo_cnt_nxt  = '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nxt    = SEND_SYNC;
                        lock_cnt_nxt = '0;
                        tmo_cnt_nxt  = '0;
                        timeout_hit  = 1'b1;
                    end else begin
                        tmo_cnt_nxt  = tmo_cnt + 1'b1;
                        lock_cnt_nxt = (phy_data_out == COM) ? lock_cnt + 1'b1 : '0;
                    end
                end
                ACTIVE: begin
                end
                default: state_nxt = SEND_SYNC;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        data_nxt  = COM;
        valid_nxt = 1'b0;
        sync_nxt  = 1'b1;
        link_nxt  = 1'b0;
        if (state_nxt == ACTIVE) begin
            sync_nxt  = 1'b0;
            link_nxt  = 1'b1;
            data_nxt  = xfer ? xfer_data : IDL;
            valid_nxt = xfer;
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            phy_data_in     <= '0;
            phy_valid_in    <= 1'b0;
            sincronizar_bus <= 1'b0;
            link_up         <= 1'b0;
        end else begin
            phy_data_in     <= data_nxt;
            phy_valid_in    <= valid_nxt;
            sincronizar_bus <= sync_nxt;
            link_up         <= link_nxt;
        end
    end

`ifdef LINK_STATS_EN
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            tx_cnt0    <= '0;
            tx_cnt1    <= '0;
            resync_cnt <= '0;
        end else begin
            if (grant[0]) begin
                tx_cnt0 <= tx_cnt0 + 16'd1;
            end
            if (grant[1]) begin
                tx_cnt1 <= tx_cnt1 + 16'd1;
            end
            if (timeout_hit && (resync_cnt != 8'hFF)) begin
                resync_cnt <= resync_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl: link bring-up, timeout, arbitration,
// retrain and asynchronous reset. Stats checks compile in with LINK_STATS_EN.
module tb_phy_link_ctrl;

    localparam logic [31:0] COM = 32'hBCBC_BCBC;
    localparam logic [31:0] IDL = 32'h7C7C_7C7C;

    logic        clk_f = 1'b0;
    logic        reset;
    logic [31:0] req0_data, req1_data;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic        retrain;
    logic [31:0] phy_data_out;
    logic        phy_valid_out;
    logic [31:0] phy_data_in;
    logic        phy_valid_in;
    logic        sincronizar_bus;
    logic        link_up;
`ifdef LINK_STATS_EN
    logic [15:0] tx_cnt0, tx_cnt1;
    logic [7:0]  resync_cnt;
`endif

    logic        use_lb;
    logic [31:0] forced_word;
    logic [31:0] lb_word;

    int errors = 0;
    int checks = 0;

    always #5 clk_f = ~clk_f;

    always @(posedge clk_f) lb_word <= phy_data_in;
    assign phy_data_out = use_lb ? lb_word : forced_word;

    phy_link_ctrl dut (
        .clk_f           (clk_f),
        .reset           (reset),
        .req0_data       (req0_data),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req1_data       (req1_data),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .retrain         (retrain),
        .phy_data_out    (phy_data_out),
        .phy_valid_out   (phy_valid_out),
        .phy_data_in     (phy_data_in),
        .phy_valid_in    (phy_valid_in),
        .sincronizar_bus (sincronizar_bus),
        .link_up         (link_up)
`ifdef LINK_STATS_EN
        ,
        .tx_cnt0         (tx_cnt0),
        .tx_cnt1         (tx_cnt1),
        .resync_cnt      (resync_cnt)
`endif
    );

    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    task automatic clear_inputs();
        req0_data     = '0;
        req1_data     = '0;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        retrain       = 1'b0;
        phy_valid_out = 1'b0;
        forced_word   = '0;
    endtask

    // Leaves the bench 1 time unit after an edge; the next edge is cycle 1.
    task automatic do_reset(input logic loopback);
        clear_inputs();
        use_lb = loopback;
        reset  = 1'b0;
        repeat (2) @(posedge clk_f);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        use_lb     = 1'b1;
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk_f);
        #1;
        checks++;
        if (phy_data_in !== 32'h0 || phy_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data=%h valid=%b need 00000000/0", phy_data_in, phy_valid_in);
        end
        checks++;
        if (sincronizar_bus !== 1'b0 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: sync=%b link=%b need 0/0", sincronizar_bus, link_up);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: r0=%b r1=%b need 0/0", req0_ready, req1_ready);
        end
`ifdef LINK_STATS_EN
        checks++;
        if (tx_cnt0 !== 16'h0 || tx_cnt1 !== 16'h0 || resync_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_stats: tx0=%0d tx1=%0d rs=%0d need 0", tx_cnt0, tx_cnt1, resync_cnt);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_link_up();
        do_reset(1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (sincronizar_bus !== 1'b1 || phy_data_in !== COM || phy_valid_in !== 1'b0) begin
                    errors++;
                    $display("FAIL first_cycle: sync=%b data=%h valid=%b need 1/%h/0",
                             sincronizar_bus, phy_data_in, phy_valid_in, COM);
                end
            end
            if (k == 7) begin
                checks++;
                if (link_up !== 1'b0 || sincronizar_bus !== 1'b1) begin
                    errors++;
                    $display("FAIL link_early c7: link=%b sync=%b need 0/1", link_up, sincronizar_bus);
                end
            end
            if (k == 8) begin
                checks++;
                if (link_up !== 1'b1 || sincronizar_bus !== 1'b0) begin
                    errors++;
                    $display("FAIL link_up c8: link=%b sync=%b need 1/0", link_up, sincronizar_bus);
                end
                checks++;
                if (phy_data_in !== IDL || phy_valid_in !== 1'b0) begin
                    errors++;
                    $display("FAIL active_idle: data=%h valid=%b need %h/0", phy_data_in, phy_valid_in, IDL);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_word;
        for (int k = 0; k < 6; k++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = 32'hA000_0000 + 32'((k + 1) / 2);
            req1_data  = 32'hB000_0000 + 32'(k / 2);
            #1;
            checks++;
            if (req0_ready !== ((k % 2) == 0) || req1_ready !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL rr_ready k=%0d: r0=%b r1=%b need %b/%b", k, req0_ready, req1_ready,
                         (k % 2) == 0, (k % 2) == 1);
            end
            exp_word = ((k % 2) == 0) ? 32'hA000_0000 + 32'(k / 2) : 32'hB000_0000 + 32'(k / 2);
            step();
            checks++;
            if (phy_data_in !== exp_word || phy_valid_in !== 1'b1) begin
                errors++;
                $display("FAIL rr_word k=%0d: data=%h valid=%b need %h/1", k, phy_data_in, phy_valid_in, exp_word);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef LINK_STATS_EN
        checks++;
        if (tx_cnt0 !== 16'd3 || tx_cnt1 !== 16'd3) begin
            errors++;
            $display("FAIL rr_stats: tx0=%0d tx1=%0d need 3/3", tx_cnt0, tx_cnt1);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            req1_valid = 1'b1;
            req1_data  = 32'h1111_0000 + 32'(k);
            #1;
            checks++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready k=%0d: r0=%b r1=%b need 0/1", k, req0_ready, req1_ready);
            end
            step();
            checks++;
            if (phy_data_in !== 32'h1111_0000 + 32'(k) || phy_valid_in !== 1'b1) begin
                errors++;
                $display("FAIL b2b_word k=%0d: data=%h valid=%b need %h/1", k, phy_data_in, phy_valid_in,
                         32'h1111_0000 + 32'(k));
            end
        end
        req1_valid = 1'b0;
        step();
        checks++;
        if (phy_data_in !== IDL || phy_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: data=%h valid=%b need %h/0", phy_data_in, phy_valid_in, IDL);
        end
    endtask

    task automatic test_retrain();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'hCAFE_0000;
        req1_data  = 32'hCAFE_0001;
        retrain    = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL retrain_ready: r0=%b r1=%b need 0/0", req0_ready, req1_ready);
        end
        step();
        retrain    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (link_up !== 1'b0 || sincronizar_bus !== 1'b1 || phy_data_in !== COM || phy_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL retrain_out: link=%b sync=%b data=%h valid=%b need 0/1/%h/0",
                     link_up, sincronizar_bus, phy_data_in, phy_valid_in, COM);
        end
`ifdef LINK_STATS_EN
        checks++;
        if (tx_cnt0 !== 16'd3 || tx_cnt1 !== 16'd6) begin
            errors++;
            $display("FAIL retrain_stats: tx0=%0d tx1=%0d need 3/6", tx_cnt0, tx_cnt1);
        end
`endif
        // Relink after retrain follows the same 8-cycle bring-up.
        for (int k = 2; k <= 9; k++) begin
            step();
            if (k == 8) begin
                checks++;
                if (link_up !== 1'b0) begin
                    errors++;
                    $display("FAIL relink_early: link=%b need 0", link_up);
                end
            end
            if (k == 9) begin
                checks++;
                if (link_up !== 1'b1) begin
                    errors++;
                    $display("FAIL relink: link=%b need 1", link_up);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        for (int k = 1; k <= 76; k++) begin
            step();
            if (k == 67) begin
                forced_word = COM;
`ifdef LINK_STATS_EN
                checks++;
                if (resync_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL resync_early: rs=%0d need 0", resync_cnt);
                end
`endif
            end
`ifdef LINK_STATS_EN
            if (k == 68) begin
                checks++;
                if (resync_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL resync_cnt: rs=%0d need 1", resync_cnt);
                end
            end
`endif
            if (k == 71 || k == 75) begin
                checks++;
                if (link_up !== 1'b0 || sincronizar_bus !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_nolink c%0d: link=%b sync=%b need 0/1", k, link_up, sincronizar_bus);
                end
            end
            if (k == 76) begin
                checks++;
                if (link_up !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_relink c76: link=%b need 1", link_up);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset(1'b1);
        repeat (8) step();
        req0_valid = 1'b1;
        req0_data  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept: r0=%b need 1", req0_ready);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (phy_data_in !== 32'h0 || phy_valid_in !== 1'b0 || link_up !== 1'b0 ||
            sincronizar_bus !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: data=%h valid=%b link=%b sync=%b r0=%b need 0",
                     phy_data_in, phy_valid_in, link_up, sincronizar_bus, req0_ready);
        end
        req0_valid = 1'b0;
        step();
        reset = 1'b1;
        seen  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (phy_data_in === 32'hDEAD_BEEF || phy_valid_in !== 1'b0) seen = 1'b1;
            if (k == 1) begin
                checks++;
                if (phy_data_in !== COM) begin
                    errors++;
                    $display("FAIL mid_restart: data=%h need %h", phy_data_in, COM);
                end
            end
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop: dropped word observed=%b need 0", seen);
        end
    endtask

    initial begin
        clear_inputs();
        use_lb = 1'b1;
        reset  = 1'b0;
        test_reset();
        test_link_up();
        test_round_robin();
        test_back_to_back();
        test_retrain();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phy_link_ctrl.md
# phy_link_ctrl

Link sequencer and transmit arbiter for the PCIe PHY block. After reset, or on a retrain request, it drives the PHY's bus-synchronisation sequence and waits for lock on the receive path. It then shares the PHY's 32-bit transmit word interface (data_in/valid_in) between two upper-layer requesters using round-robin arbitration. It sits between the link layer and the PHY on the parallel word clock.

## Interface
- SYNC_WORDS, 4: minimum COM words sent in SEND_SYNC before receive lock is checked.
- LOCK_COUNT, 3: consecutive received COM words required to declare lock.
- TIMEOUT, 64: cycles allowed in WAIT_LOCK before resync.
- COM, 32'hBCBC_BCBC: synchronisation word.
- IDL, 32'h7C7C_7C7C: idle fill word.
- clk_f  in  1  parallel word clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_data  in  32  requester 0 word.
- req0_valid  in  1  requester 0 has a word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_data, req1_valid, req1_ready: same as requester 0, for requester 1.
- retrain  in  1  single-cycle pulse that forces resynchronisation.
- phy_data_out  in  32  received word from the PHY.
- phy_valid_out  in  1  received word valid (ignored for lock detection).
- phy_data_in  out  32  word to the PHY transmitter.
- phy_valid_in  out  1  phy_data_in carries payload.
- sincronizar_bus  out  1  PHY synchronisation request.
- link_up  out  1  high while in ACTIVE.

## Operation
- States: SEND_SYNC, WAIT_LOCK, ACTIVE. Reset enters SEND_SYNC.
- SEND_SYNC:
  - sincronizar_bus=1, phy_data_in=COM, phy_valid_in=0.
  - Leave for WAIT_LOCK after SYNC_WORDS cycles.
- WAIT_LOCK:
  - Outputs as in SEND_SYNC.
  - lock_cnt increments on each cycle with phy_data_out==COM; any other word clears it to 0.
  - lock_cnt reaching LOCK_COUNT moves to ACTIVE.
  - tmo_cnt reaching TIMEOUT-1 without lock returns to SEND_SYNC, clearing both counters.
- ACTIVE:
  - sincronizar_bus=0, link_up=1.
  - Arbiter picks a winner among valid requesters. When both are valid, the one not served last wins; the last-served pointer resets to 1, so requester 0 wins first.
  - reqN_ready = ACTIVE && reqN_valid && winner==N, combinational. Ready is never asserted without the matching valid.
  - A transfer (valid & ready) places the data on phy_data_in with phy_valid_in=1 on the next cycle.
  - A cycle with no transfer places IDL on phy_data_in with phy_valid_in=0 on the next cycle.
- retrain=1 in any state:
  - Next state is SEND_SYNC and all counters clear.
  - Both readies are forced to 0 in that same cycle; retrain has priority over the grant.
- Counter widths are $clog2(param+1); no wrap occurs because each count saturates at its transition point.

## Timing
- Reset values: phy_data_in=0, phy_valid_in=0, sincronizar_bus=0, link_up=0, lock_cnt=0, tmo_cnt=0, last-served=1.
- First cycle after reset deasserts: sincronizar_bus=1, phy_data_in=COM.
- All outputs except reqN_ready are registered.
- Latency from accepted request to phy_data_in is 1 cycle.
- Throughput is 1 word per cycle.
- Minimum time from reset release to link_up: SYNC_WORDS + LOCK_COUNT + 1 cycles.
- Asserting reset mid-operation clears state immediately; any accepted word not yet output is dropped.
- Lock counting in WAIT_LOCK starts on its first cycle; COM words received during SEND_SYNC do not count.

## Configuration
- LINK_STATS_EN defined:
  - Adds outputs tx_cnt0 and tx_cnt1 (16 bits each, out), counting accepted words per requester. They wrap at 16'hFFFF → 0.
  - Adds resync_cnt (8 bits, out), counting timeout-driven returns to SEND_SYNC. It saturates at 8'hFF.
  - All three clear on reset only; retrain does not clear them.
- LINK_STATS_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared header phy_defs: COM/IDL defaults and the state encoding (SEND_SYNC=2'd0, WAIT_LOCK=2'd1, ACTIVE=2'd2).
- Sub-module phy_rr_arb2: two-way round-robin arbiter.
  - Inputs: valid[1:0], enable, accept.
  - Outputs: grant[1:0] (one-hot).
  - Holds the last-served pointer.
- FSM, counters and output registers live in phy_link_ctrl.

## Test plan
- Reset, then loop phy_data_in to phy_data_out with 1-cycle delay → link_up rises at cycle SYNC_WORDS+LOCK_COUNT+1 (8 with defaults); sincronizar_bus falls the same cycle.
- phy_data_out held at 32'h0 in WAIT_LOCK → return to SEND_SYNC after 64 cycles; with LINK_STATS_EN, resync_cnt=1.
- Both requesters valid continuously (0xA000_000n, 0xB000_000n) → phy_data_in alternates A0,B0,A1,B1…; phy_valid_in=1 every cycle.
- Only req1 valid for 3 cycles, then idle → three req1 words back-to-back, then IDL with phy_valid_in=0.
- retrain pulse while both requesters valid in ACTIVE → both readies 0 that cycle; next cycle link_up=0, sincronizar_bus=1, phy_data_in=COM.
- Reset asserted mid-transfer → all outputs at reset values asynchronously; the word accepted in the previous cycle never appears.
